// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the key schedule and cipher datapath.
// Word/key typedefs, round count and the round-constant table.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;

  localparam int         AES_NR  = 10;
  localparam logic [3:0] NR_LAST = 4'(AES_NR);

  // Round constants, MSB byte of the word; index = round number.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } kx_state_t;

endpackage

// File: rtl/aes_key_expansion_if.sv
// Handshake and round-key bus between the key schedule and its consumer.
// master = consumer/requester side, slave = key_expansion side.
interface aes_key_expansion_if;
  import aes_pkg::*;

  logic       start;
  aes_key_t   key_in;
  logic       key_ready;
  logic       rk_valid;
  logic [3:0] rk_round;
  aes_key_t   rk_out;
  logic       done;
  logic [3:0] rd_addr;
  aes_key_t   rd_key;

  modport master (
    output start, key_in, rd_addr,
    input  key_ready, rk_valid, rk_round, rk_out, done, rd_key
  );

  modport slave (
    input  start, key_in, rd_addr,
    output key_ready, rk_valid, rk_round, rk_out, done, rd_key
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197 table), one byte in, one byte out.
// Shared between the key schedule SubWord and the cipher SubBytes stage.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry for byte x sits in bits [(255-x)*8 +: 8], so row 0 is the MSBs.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_idx;

  assign w_bit_idx = {~i_byte, 3'b000};
  assign o_byte    = SBOX_FLAT[w_bit_idx +: 8];

endmodule

// File: rtl/aes_key_expansion.sv
// Forward AES-128 key schedule: emits round keys 0..10, one per clock, after start.
// Optional AES_KEY_STORE_EN adds an 11-entry round-key store with a registered read port.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  aes_key_expansion_if.slave   bus
);

  kx_state_t  r_state;
  aes_key_t   r_key;
  logic [3:0] r_round;
  logic       r_rk_valid;
  logic       r_done;
  logic       r_key_ready;

  aes_word_t  w_w0, w_w1, w_w2, w_w3;
  aes_word_t  w_rot, w_sub;
  aes_word_t  w_n0, w_n1, w_n2, w_n3;
  aes_key_t   w_next_key;
  logic [3:0] w_next_round;
  logic [7:0] w_rcon;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  // Counter saturates at the last round rather than wrapping.
  assign w_next_round = (r_round == NR_LAST) ? r_round : r_round + 4'd1;
  assign w_rcon       = (w_next_round <= NR_LAST) ? RCON[w_next_round] : 8'h00;

  assign w_n0       = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_round     <= '0;
      r_rk_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_key_ready <= 1'b1;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_key       <= bus.key_in;
            r_round     <= '0;
            r_rk_valid  <= 1'b1;
            r_key_ready <= 1'b0;
            r_state     <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          r_key      <= w_next_key;
          r_round    <= w_next_round;
          r_rk_valid <= 1'b1;
          // Return to IDLE with the final key so a new start can chain gap-free.
          if (w_next_round == NR_LAST) begin
            r_done      <= 1'b1;
            r_key_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.key_ready = r_key_ready;
  assign bus.rk_valid  = r_rk_valid;
  assign bus.rk_round  = r_round;
  assign bus.rk_out    = r_key;
  assign bus.done      = r_done;

`ifdef AES_KEY_STORE_EN
  aes_key_t r_store [AES_NR+1];
  aes_key_t r_rd_key;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the store is deliberately reset; reads after reset must return 0,
      // so this cannot map onto a reset-less RAM macro.
      for (int i = 0; i <= AES_NR; i++) r_store[i] <= '0;
      r_rd_key <= '0;
    end else begin
      if (r_rk_valid) r_store[r_round] <= r_key;
      r_rd_key <= (bus.rd_addr <= NR_LAST) ? r_store[bus.rd_addr] : '0;
    end
  end

  assign bus.rd_key = r_rd_key;
`else
  logic w_unused_rd_addr;

  assign w_unused_rd_addr = ^bus.rd_addr;
  assign bus.rd_key       = '0;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: FIPS-197 vectors plus random keys
// compared against a word-level key-schedule model with a GF(2^8)-derived S-box.
module tb_aes_key_expansion;
  import aes_pkg::*;

  logic clk;
  logic reset;

  aes_key_expansion_if bus ();

  aes_key_expansion dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  logic [7:0] sbox_tab [256];
  aes_key_t   obs [11];

  localparam aes_key_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // FIPS-197 KeyExpansion over the 44-word array, returning round key r.
  function automatic aes_key_t model_rk(input aes_key_t key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input aes_key_t key);
    bus.start  = 1'b1;
    bus.key_in = key;
    tick();
    bus.start  = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Checks rounds 0..10 starting with round 0 already visible. poke: round at
  // which a spurious start is pulsed. hold: start stays high, next key offered.
  task automatic expect_schedule(input aes_key_t key, input int poke,
                                 input bit hold, input aes_key_t next_key);
    for (int r = 0; r <= 10; r++) begin
      obs[r] = bus.rk_out;
      check($sformatf("rk_valid r%0d", r), bus.rk_valid, 1'b1);
      check($sformatf("rk_round r%0d", r), bus.rk_round, r);
      check($sformatf("rk_out r%0d", r), bus.rk_out, model_rk(key, r));
      check($sformatf("done r%0d", r), bus.done, (r == 10));
      check($sformatf("key_ready r%0d", r), bus.key_ready, (r == 10));
      if (hold) begin
        bus.start  = 1'b1;
        bus.key_in = (r == 10) ? next_key : {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bus.start  = (r == poke);
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic check_idle_after(input aes_key_t key, input string tag);
    check({tag, " rk_valid"}, bus.rk_valid, 1'b0);
    check({tag, " done"}, bus.done, 1'b0);
    check({tag, " key_ready"}, bus.key_ready, 1'b1);
    check({tag, " rk_round hold"}, bus.rk_round, 4'd10);
    check({tag, " rk_out hold"}, bus.rk_out, model_rk(key, 10));
  endtask

  initial begin
    aes_key_t k1, k2;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.key_in  = FIPS_KEY;
    bus.rd_addr = 4'd0;
    tick();
    tick();
    check("reset key_ready", bus.key_ready, 1'b1);
    check("reset rk_valid", bus.rk_valid, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset rk_round", bus.rk_round, 4'd0);
    check("reset rk_out", bus.rk_out, 128'h0);
    check("reset rd_key", bus.rd_key, 128'h0);
    reset = 1'b1;
    tick();
    check("idle key_ready", bus.key_ready, 1'b1);

    // FIPS-197 appendix A.1 key.
    start_key(FIPS_KEY);
    expect_schedule(FIPS_KEY, -1, 1'b0, '0);
    check("fips r0", obs[0], FIPS_KEY);
    check("fips r1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips r2", obs[2], 128'hf2c295f27a96b9435935807a7359f67f);
    check("fips r9", obs[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips r10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_idle_after(FIPS_KEY, "fips post");

`ifdef AES_KEY_STORE_EN
    bus.rd_addr = 4'd10;
    tick();
    check("store rd10", bus.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    bus.rd_addr = 4'd15;
    tick();
    check("store rd15", bus.rd_key, 128'h0);
    bus.rd_addr = 4'd0;
    tick();
    check("store rd0", bus.rd_key, FIPS_KEY);
    bus.rd_addr = 4'd1;
    tick();
    check("store rd1", bus.rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
`else
    bus.rd_addr = 4'(10);
    tick();
    check("no store rd_key", bus.rd_key, 128'h0);
`endif

    // All-zero key.
    start_key('0);
    expect_schedule('0, -1, 1'b0, '0);
    check("zero r1", obs[1], 128'h62636363626363636263636362636363);
    check("zero r10", obs[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Spurious start mid-expansion is ignored.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    start_key(k1);
    expect_schedule(k1, 5, 1'b0, '0);
    check_idle_after(k1, "poke post");

    // Reset dropped at round 4 discards the schedule.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    start_key(k1);
    repeat (4) tick();
    check("pre-reset rk_round", bus.rk_round, 4'd4);
    bus.rd_addr = 4'd10;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset rk_valid", bus.rk_valid, 1'b0);
    check("midreset key_ready", bus.key_ready, 1'b1);
    check("midreset rk_out", bus.rk_out, 128'h0);
    check("midreset rk_round", bus.rk_round, 4'd0);
    check("midreset done", bus.done, 1'b0);
    tick();
    check("midreset rd_key", bus.rd_key, 128'h0);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start_key(k2);
    expect_schedule(k2, -1, 1'b0, '0);

    // Start held high: second key follows the first done with no gap.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start_key(k1);
    expect_schedule(k1, -1, 1'b1, k2);
    expect_schedule(k2, -1, 1'b0, '0);
    check_idle_after(k2, "b2b post");

    // Random keys, with random spurious-start positions.
    for (int n = 0; n < 6; n++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      start_key(k1);
      expect_schedule(k1, int'($urandom_range(0, 9)), 1'b0, '0);
      check_idle_after(k1, $sformatf("rand%0d post", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
